// File: rtl/hex_display_engine.sv
// Hex/decimal 7-segment display engine: loads a binary word and converts it to
// NUM_DIGITS active-low digits, with leading-zero blanking, blinking and overflow dashes.
module hex_display_engine #(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 32,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       value,
  input  logic                    load,
  input  logic                    mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] hex_segs,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int BW    = 4 * NUM_DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Handshake: load is taken only in a cycle where busy=0; busy rises the cycle
  // after acceptance and falls after the one-cycle done pulse. No queueing.
  typedef enum logic [1:0] {ST_IDLE, ST_HEX, ST_CONV, ST_COMMIT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [BW-1:0]     work_q, work_d;
  logic              ovf_work_q, ovf_work_d;
  logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
  logic [BW-1:0]     disp_q, disp_d;
  logic              dash_q, dash_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic              phase_q, phase_d;

  logic [BW+DATA_W-1:0] val_ext;
  logic [BW-1:0]        hex_work;
  logic                 hex_ovf;
  logic [BW-1:0]        dd_adj;
  logic [BW-1:0]        dd_shifted;
  logic                 dd_out;
  logic                 commit_en;
  logic [BW-1:0]        commit_work;
  logic                 commit_ovf;

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h67;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return ~s;
  endfunction

  // Zero-extension lets the hex path read nibbles past DATA_W as 0 and lets the
  // bits above the displayable width be ORed for overflow without guards.
  assign val_ext  = {{BW{1'b0}}, val_q};
  assign hex_work = val_ext[BW-1:0];
  assign hex_ovf  = |val_ext[BW+DATA_W-1:BW];

  always_comb begin
    dd_adj = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      dd_adj[4*d +: 4] = (work_q[4*d +: 4] >= 4'd5) ? work_q[4*d +: 4] + 4'd3
                                                     : work_q[4*d +: 4];
    end
  end

  assign dd_shifted = {dd_adj[BW-2:0], val_q[DATA_W-1]};
  assign dd_out     = dd_adj[BW-1];

  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    work_d      = work_q;
    ovf_work_d  = ovf_work_q;
    shift_cnt_d = shift_cnt_q;
    disp_d      = disp_q;
    dash_d      = dash_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    commit_en   = 1'b0;
    commit_work = '0;
    commit_ovf  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          val_d       = value;
          work_d      = '0;
          ovf_work_d  = 1'b0;
          shift_cnt_d = '0;
          busy_d      = 1'b1;
          state_d     = mode ? ST_CONV : ST_HEX;
        end
      end
      ST_HEX: begin
        work_d      = hex_work;
        ovf_work_d  = hex_ovf;
        commit_en   = 1'b1;
        commit_work = hex_work;
        commit_ovf  = hex_ovf;
      end
      ST_CONV: begin
        work_d      = dd_shifted;
        val_d       = {val_q[DATA_W-2:0], 1'b0};
        ovf_work_d  = ovf_work_q | dd_out;
        shift_cnt_d = shift_cnt_q + 1'b1;
        if (shift_cnt_q == CNT_W'(DATA_W - 1)) begin
          commit_en   = 1'b1;
          commit_work = dd_shifted;
          commit_ovf  = ovf_work_q | dd_out;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Display and done land together, so the COMMIT cycle already shows the new value.
    if (commit_en) begin
      state_d    = ST_COMMIT;
      disp_d     = commit_work;
      dash_d     = commit_ovf;
      overflow_d = commit_ovf;
      valid_d    = 1'b1;
      done_d     = 1'b1;
    end

    if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      blk_cnt_d = blk_cnt_q + 1'b1;
      phase_d   = phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      val_q       <= '0;
      work_q      <= '0;
      ovf_work_q  <= 1'b0;
      shift_cnt_q <= '0;
      disp_q      <= '0;
      dash_q      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      blk_cnt_q   <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      work_q      <= work_d;
      ovf_work_q  <= ovf_work_d;
      shift_cnt_q <= shift_cnt_d;
      disp_q      <= disp_d;
      dash_q      <= dash_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      blk_cnt_q   <= blk_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  all_zero;

  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero & (disp_q[4*i +: 4] == 4'd0);
      lz_mask[i] = all_zero & (i != 0);
    end
  end

  // Priority: never-loaded blank, then dashes, then leading-zero blank; blink last.
  always_comb begin
    hex_segs = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!valid_q)                   hex_segs[7*i +: 7] = 7'h7F;
      else if (dash_q)                hex_segs[7*i +: 7] = 7'h3F;
      else if (blank_lz && lz_mask[i]) hex_segs[7*i +: 7] = 7'h7F;
      else                            hex_segs[7*i +: 7] = seg_enc(disp_q[4*i +: 4]);
      if (phase_q && blink_mask[i])   hex_segs[7*i +: 7] = 7'h7F;
    end
  end

endmodule

// File: doc/hex_display_engine.md
Name: hex_display_engine

Overview:
- Parametrised successor to the per-digit hex decoder: drives NUM_DIGITS active-low 7-segment digits from a loaded binary word.
- Hex mode shows nibbles directly; decimal mode runs a sequential double-dabble binary-to-BCD conversion.
- Adds leading-zero blanking, per-digit blinking, overflow indication and a load/busy/done handshake.
- Sits between a PIO export (e.g. the hex_displays word) and the HEX pins.

Parameters:
- NUM_DIGITS, 8: number of 7-segment digits driven, 1..8.
- DATA_W, 32: width of the loaded value, 4..32.
- BLINK_DIV, 25000000: clk cycles per blink half-period (50 MHz gives 1 Hz blink).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- value  in  DATA_W  binary value to display; sampled on accepted load.
- load  in  1  single-cycle request; accepted only when busy=0.
- mode  in  1  0=hex, 1=decimal; sampled with value.
- blank_lz  in  1  1=blank leading zero digits; live, not sampled.
- blink_mask  in  NUM_DIGITS  bit i=1 blinks digit i; live.
- hex_segs  out  7*NUM_DIGITS  digit i at [7i+6:7i], segment order g..a, active low.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when a new value reaches the display register.
- overflow  out  1  sticky per load: last loaded value did not fit.

Behaviour:
- Reset (async assert): FSM=IDLE, busy=0, done=0, overflow=0, valid=0, blink phase=0, blink counter=0.
  - hex_segs = all 1s (all digits blank) until the first completed load.
- Encoding per digit, identical to the existing decoder, inverted:
  - 0..F -> ~{3F,06,5B,4F,66,6D,7D,07,7F,67,77,7C,39,5E,79,71}.
  - Blank = 7'h7F. Dash = 7'h3F.
- FSM states: IDLE, HEX, CONV, COMMIT.
  - IDLE + load: capture value/mode, busy=1 next cycle; mode=0 -> HEX, mode=1 -> CONV.
  - HEX (1 cycle): digit i = value[4i+3:4i], with bits beyond DATA_W as 0. overflow = any value bit at or above 4*NUM_DIGITS is nonzero. -> COMMIT.
  - CONV (DATA_W cycles): each cycle, add 3 to every BCD digit >=5, then shift left 1, inserting the next value bit MSB-first. Any 1 shifted out of the top BCD digit sets overflow. -> COMMIT after DATA_W shifts.
  - COMMIT (1 cycle): copy working digits into the display register (or all dashes if overflow), valid=1, done=1 for this cycle, busy=0 next cycle, -> IDLE.
- Latency from load to done: hex mode 2 cycles; decimal mode DATA_W+1 cycles. The load-to-busy edge is 1 cycle.
- Display register changes only in COMMIT. hex_segs holds the previous value during conversion; no partial values are ever shown.
- load while busy=1 is ignored; no queueing. load in the COMMIT cycle is also ignored.
- Leading-zero blanking: when blank_lz=1, digits above the highest nonzero digit show blank. Digit 0 is never blanked, so value 0 shows "0". Not applied to dashes.
- Blink: free-running counter 0..BLINK_DIV-1; phase toggles on wrap. When phase=1, digit i is blank if blink_mask[i]=1. Blink applies after blanking and dashes.
- Output path is combinational from the display register, blank_lz, blink_mask and phase. No extra register stage.
- Reset mid-conversion: abort immediately and return to the reset state. The display goes blank.

Test Plan:
- Reset then idle: hex_segs = all 1s, busy=0, overflow=0; the blink counter runs but the display stays blank.
- mode=0, value=32'h000012AB, blank_lz=1, one load pulse -> done at cycle 2; digits 0..3 = B,A,2,1 encodings (7'h03,7'h08,7'h24,7'h79); digits 4..7 = 7'h7F; overflow=0.
- mode=1, value=1234, blank_lz=0 -> busy for DATA_W cycles, done at cycle 33; digits = 4,3,2,1,0,0,0,0 (digit 0 = 7'h19); old value held until done.
- mode=1, value=100000000 (NUM_DIGITS=8) -> overflow=1; all digits 7'h3F. Next load of 5 -> overflow=0, digit 0 = 7'h12.
- load pulsed again at cycles 3 and 10 during a decimal conversion -> ignored; exactly one done; result matches the first value.
- BLINK_DIV=4, blink_mask=8'h01, value=0 hex -> digit 0 alternates 7'h40 / 7'h7F every 4 cycles. Assert reset_n=0 mid-CONV -> busy=0 and all digits blank, asynchronously.
